// File: rtl/branch_resolver_pkg.sv
// Shared types for the EX-stage branch resolver: funct3 codes, queue entry, FSM state.
// Queue entries are stored at BR_PC_W bits; the resolver's DATA_W must not exceed it.
package branch_resolver_pkg;

    localparam int BR_PC_W = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [BR_PC_W-1:0] pc;
        logic [BR_PC_W-1:0] pred_pc;
        logic               pred_taken;
        logic               cond;
    } bq_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

endpackage

// File: rtl/branch_resolver_cmp.sv
// Conditional-branch comparator: evaluates the funct3 condition on rs1/rs2.
module branch_cmp
    import branch_resolver_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   funct3_i,
    input  logic [W-1:0] rs1_i,
    input  logic [W-1:0] rs2_i,
    output logic         taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rs1_i == rs2_i);
            F3_BNE:  taken_o = (rs1_i != rs2_i);
            F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            F3_BLTU: taken_o = (rs1_i <  rs2_i);
            F3_BGEU: taken_o = (rs1_i >= rs2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// In-order prediction queue pushed at ID, resolved against EX operands; drives the
// registered predictor-update bus and a one-cycle mispredict pulse with a RECOVER bubble.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              iss_valid,
    input  logic              iss_cond,
    input  logic              iss_pred_taken,
    input  logic [DATA_W-1:0] iss_pc,
    input  logic [DATA_W-1:0] iss_pred_pc,
    output logic              iss_ready,
    input  logic              ex_valid,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_is_jalr,
    input  logic [DATA_W-1:0] ex_rs1,
    input  logic [DATA_W-1:0] ex_rs2,
    input  logic [DATA_W-1:0] ex_imm,
    output logic              old_branch,
    output logic [DATA_W-1:0] old_branch_pc,
    output logic              old_predict,
    output logic              old_actual,
    output logic [DATA_W-1:0] old_predict_pc,
    output logic [DATA_W-1:0] old_pc,
    output logic              predict_fail,
    output logic              underflow
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    bq_entry_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    br_state_e   state_q;

    logic              old_branch_q, old_predict_q, old_actual_q, predict_fail_q, underflow_q;
    logic [DATA_W-1:0] old_branch_pc_q, old_predict_pc_q, old_pc_q;

    logic              empty, full, push, pop, taken, actual, mispred;
    bq_entry_t         head, push_e;
    logic [DATA_W-1:0] head_pc, head_pred_pc, next_pc, seq_pc, br_tgt, jalr_sum;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign iss_ready = !full && (state_q == RUN);
    assign push      = iss_valid && iss_ready && !stall;
    assign pop       = ex_valid && !stall && !empty && (state_q == RUN);

    assign push_e.pc         = BR_PC_W'(iss_pc);
    assign push_e.pred_pc    = BR_PC_W'(iss_pred_pc);
    assign push_e.pred_taken = iss_pred_taken;
    assign push_e.cond       = iss_cond;

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign head_pc      = DATA_W'(head.pc);
    assign head_pred_pc = DATA_W'(head.pred_pc);

    branch_cmp #(.W(DATA_W)) u_cmp (
        .funct3_i (ex_funct3),
        .rs1_i    (ex_rs1),
        .rs2_i    (ex_rs2),
        .taken_o  (taken)
    );

    assign jalr_sum = ex_rs1 + ex_imm;
    assign br_tgt   = head_pc + ex_imm;
    assign seq_pc   = head_pc + DATA_W'(4);

    always_comb begin
        actual  = 1'b1;
        next_pc = br_tgt;
        if (head.cond) begin
            actual  = taken;
            next_pc = taken ? br_tgt : seq_pc;
        end else if (ex_is_jalr) begin
            next_pc = {jalr_sum[DATA_W-1:1], 1'b0};
        end
    end

    // Target compare alone decides the redirect; a matching direction is not enough.
    assign mispred = (next_pc != head_pred_pc);

    // A push coinciding with a flushing pop would land in a discarded slot.
    always_ff @(posedge clk) begin
        if (push && !(pop && mispred))
            mem_q[wr_ptr_q[AW-1:0]] <= push_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            state_q          <= RUN;
            old_branch_q     <= 1'b0;
            old_predict_q    <= 1'b0;
            old_actual_q     <= 1'b0;
            predict_fail_q   <= 1'b0;
            underflow_q      <= 1'b0;
            old_branch_pc_q  <= '0;
            old_predict_pc_q <= '0;
            old_pc_q         <= '0;
        end else if (!stall) begin
            old_branch_q   <= pop;
            predict_fail_q <= pop && mispred;
            if (ex_valid && empty && (state_q == RUN))
                underflow_q <= 1'b1;
            if (pop) begin
                old_branch_pc_q  <= head_pc;
                old_predict_q    <= head.pred_taken;
                old_actual_q     <= actual;
                old_predict_pc_q <= head_pred_pc;
                old_pc_q         <= next_pc;
            end
            case (state_q)
                RUN: begin
                    if (pop && mispred) begin
                        state_q  <= RECOVER;
                        rd_ptr_q <= wr_ptr_q;
                    end else begin
                        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    end
                end
                RECOVER: state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign old_branch     = old_branch_q;
    assign old_branch_pc  = old_branch_pc_q;
    assign old_predict    = old_predict_q;
    assign old_actual     = old_actual_q;
    assign old_predict_pc = old_predict_pc_q;
    assign old_pc         = old_pc_q;
    assign predict_fail   = predict_fail_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_branch_resolver;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n, stall;
    logic              iss_valid, iss_cond, iss_pred_taken, iss_ready;
    logic [DATA_W-1:0] iss_pc, iss_pred_pc;
    logic              ex_valid, ex_is_jalr;
    logic [2:0]        ex_funct3;
    logic [DATA_W-1:0] ex_rs1, ex_rs2, ex_imm;
    logic              old_branch, old_predict, old_actual, predict_fail, underflow;
    logic [DATA_W-1:0] old_branch_pc, old_predict_pc, old_pc;

    branch_resolver #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .iss_valid(iss_valid), .iss_cond(iss_cond), .iss_pred_taken(iss_pred_taken),
        .iss_pc(iss_pc), .iss_pred_pc(iss_pred_pc), .iss_ready(iss_ready),
        .ex_valid(ex_valid), .ex_funct3(ex_funct3), .ex_is_jalr(ex_is_jalr),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
        .old_branch(old_branch), .old_branch_pc(old_branch_pc), .old_predict(old_predict),
        .old_actual(old_actual), .old_predict_pc(old_predict_pc), .old_pc(old_pc),
        .predict_fail(predict_fail), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred_pc;
        bit          pred_taken;
        bit          cond;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    bit          m_rec;
    bit          m_br, m_pred, m_act, m_pf, m_uf;
    logic [31:0] m_bpc, m_ppc, m_npc;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rec = 0; m_br = 0; m_pred = 0; m_act = 0; m_pf = 0; m_uf = 0;
        m_bpc = 0; m_ppc = 0; m_npc = 0;
    endtask

    function automatic void resolve(input ent_t e, input logic [2:0] f3, input bit jr,
                                    input logic [31:0] r1, input logic [31:0] r2,
                                    input logic [31:0] im, output bit act, output logic [31:0] npc);
        bit t;
        if (e.cond) begin
            case (f3)
                3'd0: t = (r1 == r2);
                3'd1: t = (r1 != r2);
                3'd4: t = ($signed(r1) <  $signed(r2));
                3'd5: t = ($signed(r1) >= $signed(r2));
                3'd6: t = (r1 <  r2);
                3'd7: t = (r1 >= r2);
                default: t = 0;
            endcase
            act = t;
            npc = t ? e.pc + im : e.pc + 32'd4;
        end else begin
            act = 1;
            npc = jr ? ((r1 + im) & ~32'h1) : e.pc + im;
        end
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit   can_push, act;
        ent_t e, n;
        logic [31:0] npc;
        if (stall) return;
        can_push = (mq.size() < DEPTH) && !m_rec;
        n.pc = iss_pc; n.pred_pc = iss_pred_pc; n.pred_taken = iss_pred_taken; n.cond = iss_cond;
        m_br = 0; m_pf = 0;
        if (m_rec) begin
            m_rec = 0;
            return;
        end
        if (ex_valid && mq.size() == 0) m_uf = 1;
        if (ex_valid && mq.size() > 0) begin
            e = mq.pop_front();
            resolve(e, ex_funct3, ex_is_jalr, ex_rs1, ex_rs2, ex_imm, act, npc);
            m_br = 1; m_bpc = e.pc; m_pred = e.pred_taken; m_act = act;
            m_ppc = e.pred_pc; m_npc = npc;
            if (npc != e.pred_pc) begin
                m_pf = 1; m_rec = 1;
                mq.delete();
                return;
            end
        end
        if (iss_valid && can_push) mq.push_back(n);
    endtask

    task automatic compare_all();
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, (mq.size() < DEPTH) && !m_rec});
        chk("old_branch", {31'd0, old_branch}, {31'd0, m_br});
        chk("predict_fail", {31'd0, predict_fail}, {31'd0, m_pf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
        chk("old_predict", {31'd0, old_predict}, {31'd0, m_pred});
        chk("old_actual", {31'd0, old_actual}, {31'd0, m_act});
        chk("old_branch_pc", old_branch_pc, m_bpc);
        chk("old_predict_pc", old_predict_pc, m_ppc);
        chk("old_pc", old_pc, m_npc);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        stall = 0; iss_valid = 0; ex_valid = 0;
    endtask

    task automatic push_in(input bit c, input bit pt, input logic [31:0] pc, input logic [31:0] ppc);
        iss_valid = 1; iss_cond = c; iss_pred_taken = pt; iss_pc = pc; iss_pred_pc = ppc;
    endtask

    task automatic ex_in(input logic [2:0] f3, input bit jr, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im);
        ex_valid = 1; ex_funct3 = f3; ex_is_jalr = jr; ex_rs1 = r1; ex_rs2 = r2; ex_imm = im;
    endtask

    function automatic logic [31:0] pick(input int sel);
        logic [31:0] v;
        case (sel)
            0: v = 32'd4;
            1: v = 32'd8;
            2: v = 32'h20;
            default: v = 32'hFFFF_FFF8;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] pick_op(input int sel);
        logic [31:0] v;
        case (sel)
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'd5;
            3: v = 32'hFFFF_FFFF;
            default: v = 32'h8000_0000;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] pc;
        rst_n = 0; idle();
        iss_cond = 0; iss_pred_taken = 0; iss_pc = 0; iss_pred_pc = 0;
        ex_funct3 = 0; ex_is_jalr = 0; ex_rs1 = 0; ex_rs2 = 0; ex_imm = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1;

        // beq taken but predicted fall-through -> redirect and one-cycle RECOVER
        idle(); push_in(1, 0, 32'h100, 32'h104); step();
        idle(); ex_in(3'b000, 0, 5, 5, 32'h20); step();
        chk("t1_actual", {31'd0, old_actual}, 32'd1);
        chk("t1_pc", old_pc, 32'h120);
        chk("t1_pf", {31'd0, predict_fail}, 32'd1);
        chk("t1_ready_rec", {31'd0, iss_ready}, 32'd0);
        idle(); step();
        chk("t1_ready_back", {31'd0, iss_ready}, 32'd1);

        // bltu: 0xFFFFFFFF is large unsigned -> not taken, correct prediction
        idle(); push_in(1, 0, 32'h200, 32'h204); step();
        idle(); ex_in(3'b110, 0, 32'hFFFF_FFFF, 1, 32'h40); step();
        chk("t2_pc", old_pc, 32'h204);
        chk("t2_pf", {31'd0, predict_fail}, 32'd0);
        chk("t2_br", {31'd0, old_branch}, 32'd1);

        // jalr target LSB cleared -> 0x400 vs predicted 0x401
        idle(); push_in(0, 1, 32'h300, 32'h401); step();
        idle(); ex_in(3'b000, 1, 32'h3FF, 0, 32'd2); step();
        chk("t3_pc", old_pc, 32'h400);
        chk("t3_pf", {31'd0, predict_fail}, 32'd1);
        idle(); step();

        // Fill to full, pop while offering, pop+push together, then drain in order
        for (int i = 0; i < 4; i++) begin
            idle(); push_in(1, 0, 32'h1000 + 32'(i*16), 32'h1004 + 32'(i*16)); step();
        end
        chk("t4_full", {31'd0, iss_ready}, 32'd0);
        idle(); push_in(1, 0, 32'h1040, 32'h1044); ex_in(3'b000, 0, 1, 2, 8); step();
        chk("t4_pop_pc", old_branch_pc, 32'h1000);
        idle(); push_in(1, 0, 32'h1050, 32'h1054); ex_in(3'b000, 0, 1, 2, 8); step();
        chk("t4_pp_ready", {31'd0, iss_ready}, 32'd1);
        idle(); push_in(1, 0, 32'h1060, 32'h1064); step();
        chk("t4_full2", {31'd0, iss_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(); ex_in(3'b000, 0, 1, 2, 8); step();
        end
        chk("t4_last_pc", old_branch_pc, 32'h1060);

        // First of three mispredicts with a push offered -> queue flushed
        for (int i = 0; i < 3; i++) begin
            idle(); push_in(1, 0, 32'h2000 + 32'(i*8), 32'h2004 + 32'(i*8)); step();
        end
        idle(); push_in(1, 0, 32'h2100, 32'h2104); ex_in(3'b000, 0, 7, 7, 32'h40); step();
        chk("t5_pf", {31'd0, predict_fail}, 32'd1);
        idle(); step();
        idle(); ex_in(3'b000, 0, 7, 7, 32'h40); step();
        chk("t5_uf", {31'd0, underflow}, 32'd1);
        chk("t5_nobr", {31'd0, old_branch}, 32'd0);

        // Stall holds the mispredict pulse
        idle(); push_in(1, 0, 32'h3000, 32'h3004); step();
        idle(); ex_in(3'b001, 0, 1, 2, 32'h10); step();
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1; ex_in(3'b001, 0, 1, 2, 32'h10); step();
            chk("t6_pf_held", {31'd0, predict_fail}, 32'd1);
        end
        idle(); step();
        chk("t6_pf_drop", {31'd0, predict_fail}, 32'd0);

        // Asynchronous reset mid-queue with a pulse in flight
        idle(); push_in(1, 0, 32'h4000, 32'h4004); step();
        idle(); push_in(1, 0, 32'h4010, 32'h4014); step();
        idle(); ex_in(3'b000, 0, 3, 3, 32'h40); step();
        #2 rst_n = 0;
        #1;
        chk("t7_pf", {31'd0, predict_fail}, 32'd0);
        chk("t7_br", {31'd0, old_branch}, 32'd0);
        chk("t7_pc", old_pc, 32'd0);
        chk("t7_bpc", old_branch_pc, 32'd0);
        chk("t7_uf", {31'd0, underflow}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        compare_all();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            idle();
            stall = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 9) < 6) begin
                pc = 32'($urandom_range(0, 255)) << 2;
                push_in($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, pc,
                        pc + pick($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 1) == 1)
                ex_in(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                      pick_op($urandom_range(0, 4)), pick_op($urandom_range(0, 4)),
                      pick($urandom_range(0, 3)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
